perf_counter_unit: RTL
======================

PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, named clk_i and rst_i.
REQ-002 Parameter NUM_CNT, default 4, SHALL set the number of event counters (1..16).
REQ-003 Parameter CNT_W, default 32, SHALL set the width of the event counters and the cycle counter (8..64).
REQ-004 Parameter CYCLE_LIMIT, default 64, SHALL set the number of RUN cycles before auto-stop; 0 SHALL mean unlimited.
REQ-005 clk_i  in  1  rising-edge clock.
REQ-006 rst_i  in  1  async active-high reset.
REQ-007 start_i  in  1  level; IDLE->RUN request.
REQ-008 clr_i  in  1  sync clear of all counters, flags and state.
REQ-009 event_i  in  NUM_CNT  per-counter event strobe, sampled each rising edge.
REQ-010 snapshot_i  in  1  copy live counters into shadow registers.
REQ-011 rd_sel_i  in  $clog2(NUM_CNT) (min 1)  counter read select.
REQ-012 rd_data_o  out  CNT_W  selected counter value, combinational from registers.
REQ-013 cycle_o  out  CNT_W  RUN-cycle count.
REQ-014 running_o  out  1  high in RUN.
REQ-015 done_o  out  1  high in DONE.
REQ-016 ovf_o  out  NUM_CNT  sticky per-counter saturation flags.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 Transitions: IDLE->RUN when start_i=1; RUN->DONE on the edge where cycle_o becomes CYCLE_LIMIT (CYCLE_LIMIT!=0); DONE->IDLE only on clr_i; any state->IDLE on clr_i.
REQ-019 In RUN only: cycle_o +1 per edge; counter k +1 on each edge with event_i[k]=1.
REQ-020 Events SHALL be counted on the same edge as the IDLE->RUN transition, and on the RUN->DONE edge.
REQ-021 In IDLE and DONE, counters and cycle_o SHALL hold.
REQ-022 Counters SHALL saturate at 2^CNT_W-1; an event at saturation SHALL set ovf_o[k], which stays set until clr_i or reset.
REQ-023 cycle_o SHALL saturate likewise when CYCLE_LIMIT=0.
REQ-024 clr_i SHALL take priority over start_i, event_i and snapshot_i on the same edge.
REQ-025 An out-of-range rd_sel_i SHALL return 0.

Reset
REQ-026 rst_i SHALL asynchronously force: state IDLE, all counters, cycle_o, shadows, ovf_o = 0; running_o=0, done_o=0, rd_data_o=0.
REQ-027 Reset asserted mid-RUN SHALL discard all counts with no partial update on deassertion edge.

Configuration
REQ-028 With PERF_SNAPSHOT_EN defined, snapshot_i=1 SHALL copy all live counters (post-update values of that edge) into shadow registers and rd_data_o SHALL read shadows; clr_i clears shadows.
REQ-029 Without PERF_SNAPSHOT_EN, no shadow registers SHALL exist, snapshot_i SHALL be ignored and rd_data_o SHALL read live counters.

Structure
REQ-030 Package perf_pkg SHALL hold the FSM state enum and the limits for NUM_CNT/CNT_W.
REQ-031 One sub-module, perf_counter_cell, SHALL implement a single saturating counter with enable, clear and sticky overflow, instantiated NUM_CNT times.

Verification
REQ-032 Reset, start_i=1 for 1 cycle, event_i[0]=1 every cycle, CYCLE_LIMIT=64 -> done_o=1 after 64 edges, cycle_o=64, counter0=64, other counters 0.
REQ-033 event_i[1] high on alternate cycles during 10 RUN cycles -> counter1=5; counters hold during DONE/IDLE when event_i keeps toggling.
REQ-034 CNT_W=8, event_i[2] constantly high, CYCLE_LIMIT=0, 300 cycles -> counter2=255, ovf_o[2]=1, ovf_o[others]=0.
REQ-035 clr_i and start_i high on same edge in DONE -> IDLE, all counters 0, ovf_o=0; next start_i -> RUN.
REQ-036 rst_i pulsed at RUN cycle 20 (async, mid-cycle) -> all outputs 0 immediately, state IDLE.
REQ-037 PERF_SNAPSHOT_EN: snapshot at cycle_o=10 with counter0 at 10 -> rd_data_o(sel 0)=10 while live counter continues to 64; without macro rd_data_o tracks live value.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and limits for the performance counter unit.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perf_state_e;

  localparam int NUM_CNT_MIN = 1;
  localparam int NUM_CNT_MAX = 16;
  localparam int CNT_W_MIN   = 8;
  localparam int CNT_W_MAX   = 64;

  // Width of the read select; at least one bit even for a single counter.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One saturating event counter with synchronous clear and a sticky overflow flag.
module perf_counter_cell #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_nxt_o,
  output logic         ovf_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      // An event arriving at full scale is lost and flagged instead of wrapping.
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Performance counter unit: IDLE/RUN/DONE window with per-event saturating counters.
// Optional shadow snapshot registers are built when PERF_SNAPSHOT_EN is defined.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int NUM_CNT     = 4,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic                            clr_i,
  input  logic [NUM_CNT-1:0]              event_i,
  input  logic                            snapshot_i,
  input  logic [sel_width(NUM_CNT)-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]                rd_data_o,
  output logic [CNT_W-1:0]                cycle_o,
  output logic                            running_o,
  output logic                            done_o,
  output logic [NUM_CNT-1:0]              ovf_o,
  output logic [1:0]                      state_o
);

  localparam int             SEL_W    = sel_width(NUM_CNT);
  localparam bit             LIMIT_EN = (CYCLE_LIMIT != 0);
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(CYCLE_LIMIT);

  perf_state_e      state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             active;

  // The start edge itself and the final RUN edge both count.
  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    active  = 1'b0;
    if (clr_i) begin
      state_d = ST_IDLE;
      cycle_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: active = start_i;
        ST_RUN:  active = 1'b1;
        ST_DONE: active = 1'b0;
        default: state_d = ST_IDLE;
      endcase
      if (active) begin
        cycle_d = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
        state_d = ST_RUN;
        if (LIMIT_EN && (cycle_d == LIMIT_V)) state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
    end
  end

  logic [CNT_W-1:0] cnt    [NUM_CNT];
  logic [CNT_W-1:0] rd_src [NUM_CNT];

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt_nxt;

    perf_counter_cell #(.W(CNT_W)) u_cell (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (clr_i),
      .inc_i     (active & event_i[k]),
      .cnt_o     (cnt[k]),
      .cnt_nxt_o (cnt_nxt),
      .ovf_o     (ovf_o[k])
    );

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0] shadow_q, shadow_d;

    // Captures the value the live counter takes on this same edge.
    always_comb begin
      shadow_d = shadow_q;
      if (clr_i)           shadow_d = '0;
      else if (snapshot_i) shadow_d = cnt_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) shadow_q <= '0;
      else       shadow_q <= shadow_d;
    end

    assign rd_src[k] = shadow_q;
`else
    logic unused_nxt;
    assign unused_nxt = ^cnt_nxt;
    assign rd_src[k]  = cnt[k];
`endif
  end

`ifndef PERF_SNAPSHOT_EN
  logic unused_snapshot;
  assign unused_snapshot = snapshot_i;
`endif

  // Selects that match no counter fall through to zero.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (rd_sel_i == SEL_W'(k)) rd_data_o = rd_src[k];
    end
  end

  assign cycle_o   = cycle_q;
  assign running_o = (state_q == ST_RUN);
  assign done_o    = (state_q == ST_DONE);
  assign state_o   = state_q;

endmodule
